// File: rtl/aes128_package.sv
// Shared definitions for the masked AES-128 datapath.
// Contents used by the zero-sharing stream:
//   num_zero_stream_random() - raw random words consumed per lane
//   zero_share_word_t         - one share word at the default share width
//   ZERO_MODE_INDEPENDENT / ZERO_MODE_RING - per-beat sharing mode encodings
package aes128_package;

  localparam int ZERO_SHARE_DEFAULT_WIDTH = 8;

  // Share word at the default width; modules built with another BIT_WIDTH
  // declare a local equivalent of the same shape.
  typedef logic [ZERO_SHARE_DEFAULT_WIDTH-1:0] zero_share_word_t;

  localparam logic ZERO_MODE_INDEPENDENT = 1'b0;
  localparam logic ZERO_MODE_RING        = 1'b1;

  // One raw random word is consumed for every output share, in both modes
  // (independent mode simply ignores the last word).
  function automatic int num_zero_stream_random(input int num_shares);
    return num_shares;
  endfunction

endpackage

// File: rtl/masked_zero_mix.sv
// One lane of zero-sharing: NUM_SHARES raw words in, NUM_SHARES shares out
// whose XOR is always zero. Purely combinational.
// Ports:
//   random_words - word i at [i*BIT_WIDTH +: BIT_WIDTH]
//   mode         - ZERO_MODE_INDEPENDENT or ZERO_MODE_RING
//   shares       - share i at [i*BIT_WIDTH +: BIT_WIDTH]
module masked_zero_mix
  import aes128_package::*;
#(
  parameter int NUM_SHARES = 3,
  parameter int BIT_WIDTH  = 8
) (
  input  logic [NUM_SHARES*BIT_WIDTH-1:0] random_words,
  input  logic                            mode,
  output logic [NUM_SHARES*BIT_WIDTH-1:0] shares
);

  typedef logic [BIT_WIDTH-1:0] share_word_t;

  // XOR of all words except the last: the balancing share in independent mode.
  share_word_t partial_xor;

  always_comb begin
    partial_xor = '0;
    for (int i = 0; i < NUM_SHARES - 1; i++) begin
      partial_xor = partial_xor ^ random_words[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SHARES; gi++) begin : g_share
      localparam int NEXT = (gi + 1) % NUM_SHARES;
      share_word_t word_cur;
      share_word_t word_nxt;
      share_word_t ring_share;
      share_word_t indep_share;

      assign word_cur   = random_words[gi*BIT_WIDTH +: BIT_WIDTH];
      assign word_nxt   = random_words[NEXT*BIT_WIDTH +: BIT_WIDTH];
      // Every word appears in exactly two ring shares, so the XOR cancels.
      assign ring_share = word_cur ^ word_nxt;

      if (gi == NUM_SHARES - 1) begin : g_last
        assign indep_share = partial_xor;
      end else begin : g_pass
        assign indep_share = word_cur;
      end

      assign shares[gi*BIT_WIDTH +: BIT_WIDTH] =
        (mode == ZERO_MODE_RING) ? ring_share : indep_share;
    end
  endgenerate

endmodule

// File: rtl/masked_zero_stream.sv
// Streaming zero-sharing generator: turns raw randomness into NUM_LANES
// independent NUM_SHARES-way sharings of zero, buffered in a DEPTH-entry FIFO.
// Ports:
//   in_clock, in_reset            - clock, synchronous active-high reset
//   in_random, in_mode, in_valid  - input beat (words packed lane-major)
//   in_ready                      - beat accepted when in_valid && in_ready
//   in_flush                      - empties and zeroes the buffer
//   out_random, out_valid         - head entry (zero when empty)
//   out_ready                     - consumer takes the head entry
//   out_count                     - completed output handshakes, wrapping
module masked_zero_stream
  import aes128_package::*;
#(
  parameter int NUM_SHARES  = 3,
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_LANES   = 2,
  parameter int DEPTH       = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                                  in_clock,
  input  logic                                  in_reset,
  input  logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0] in_random,
  input  logic                                  in_mode,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_flush,
  output logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0] out_random,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [COUNT_WIDTH-1:0]                out_count
);

  localparam int LANE_W = num_zero_stream_random(NUM_SHARES) * BIT_WIDTH;
  localparam int BEAT_W = NUM_LANES * LANE_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0]       LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]       PTR_ONE   = PTR_W'(1);
  localparam logic [OCC_W-1:0]       FULL_OCC  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]       OCC_ONE   = OCC_W'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  genvar gi;

  generate
    if (NUM_SHARES < 2 || NUM_SHARES > 8) begin : g_bad_shares
      $error("masked_zero_stream: NUM_SHARES must be in 2..8");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("masked_zero_stream: DEPTH must be in 1..8");
    end
  endgenerate

  // Beats are shared on the way in, so the buffer only ever holds sharings
  // of zero and the mode needs no storage of its own.
  logic [BEAT_W-1:0] shared_beat;

  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      masked_zero_mix #(
        .NUM_SHARES (NUM_SHARES),
        .BIT_WIDTH  (BIT_WIDTH)
      ) u_mix (
        .random_words (in_random[gi*LANE_W +: LANE_W]),
        .mode         (in_mode),
        .shares       (shared_beat[gi*LANE_W +: LANE_W])
      );
    end
  endgenerate

  logic [BEAT_W-1:0]      entry_reg [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [OCC_W-1:0]       occ_reg, occ_next;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   full;
  logic                   push;
  logic                   pop;

  assign full      = (occ_reg == FULL_OCC);
  // A full buffer still accepts when the head leaves in the same cycle.
  assign in_ready  = !in_flush && (!full || out_ready);
  assign out_valid = (occ_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_random = out_valid ? entry_reg[rd_ptr_reg] : '0;
  assign out_count = count_reg;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    occ_next    = occ_reg;
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_ONE;
    end
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   occ_next = occ_reg + OCC_ONE;
      2'b01:   occ_next = occ_reg - OCC_ONE;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
      count_reg  <= '0;
    end else if (in_flush) begin
      // A pop coinciding with a flush is discarded and not counted.
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      occ_reg    <= occ_next;
      if (pop) begin
        count_reg <= count_reg + COUNT_ONE;
      end
    end
  end

  // Popped entries are scrubbed so no consumed randomness lingers. When full,
  // push and pop hit the same slot and the incoming beat must win.
  always_ff @(posedge in_clock) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (in_reset || in_flush) begin
        entry_reg[e] <= '0;
      end else if (push && (wr_ptr_reg == PTR_W'(e))) begin
        entry_reg[e] <= shared_beat;
      end else if (pop && (rd_ptr_reg == PTR_W'(e))) begin
        entry_reg[e] <= '0;
      end
    end
  end

endmodule

// File: doc/masked_zero_stream.md
Name: masked_zero_stream

Overview:
- Streaming, parametrised zero-sharing generator.
- Turns raw randomness words into NUM_LANES independent NUM_SHARES-way sharings of zero, used for refresh and remasking in the masked S-box and key-schedule pipelines.
- Adds a valid/ready handshake on both sides, a per-beat run-time mode (independent or ring sharing), an output buffer with back-pressure, a flush, and a produced-beat counter.
- Sits between the randomness source (PRNG) and the masked datapath stages.

Parameters:
- NUM_SHARES, 3, number of shares per sharing; legal range 2..8; elaboration error outside that range.
- BIT_WIDTH, 8, width of one share.
- NUM_LANES, 2, independent zero-sharings per beat.
- DEPTH, 2, output buffer entries; legal range 1..8.
- COUNT_WIDTH, 16, width of the produced-beat counter.

Ports:
- in_clock  input  1  clock; all state updates on the rising edge.
- in_reset  input  1  reset; synchronous, active-high.
- in_random  input  NUM_LANES*NUM_SHARES*BIT_WIDTH  raw random words. Word i of lane l is at bits [(l*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH].
- in_mode  input  1  0 = independent mode, 1 = ring mode; sampled with each accepted beat.
- in_valid  input  1  in_random and in_mode are valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_flush  input  1  synchronous flush of the buffer.
- out_random  output  NUM_LANES*NUM_SHARES*BIT_WIDTH  zero-sharings of the head entry; same packing as in_random.
- out_valid  output  1  head entry is present.
- out_ready  input  1  consumer takes the head entry.
- out_count  output  COUNT_WIDTH  number of completed output handshakes, modulo 2^COUNT_WIDTH.

Behaviour:
- Sharing function, per lane, with r_i the lane's word i:
  - Independent mode: s_i = r_i for i < NUM_SHARES-1; s_last = XOR of r_0..r_{NUM_SHARES-2}. Word r_{NUM_SHARES-1} is ignored.
  - Ring mode: s_i = r_i ^ r_{(i+1) mod NUM_SHARES}.
  - Invariant: the XOR of all shares of a lane is always 0.
- Sharings are computed combinationally at input and stored already shared. The mode is captured per entry.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = !in_flush && (!full || out_ready). When full, a push and pop in the same cycle are both taken and occupancy is unchanged.
- Latency: a beat accepted at edge k is visible on out_random and out_valid after edge k (registered), when the buffer was empty.
- Ordering is FIFO. Read and write pointers wrap modulo DEPTH; occupancy runs 0..DEPTH.
- out_valid = (occupancy != 0).
- out_random = head entry when out_valid, otherwise all zeros.
- A popped entry is cleared to zero on the pop edge, so no stale randomness remains in storage.
- Flush (in_flush = 1 at an edge):
  - clears all entries to zero and empties the buffer;
  - drops any concurrent push;
  - does not count a concurrent pop;
  - leaves out_count unchanged.
- out_count increments by 1 on each pop and wraps from 2^COUNT_WIDTH-1 to 0.
- Reset, including mid-transfer: takes priority over everything. Buffer empty, all entries zero, out_valid=0, out_random=0, out_count=0. in_ready becomes 1 in the cycle after reset deasserts.
- No combinational path from in_valid or in_random to out_*. in_ready depends combinationally on out_ready and in_flush only.

Decomposition:
- Package aes128_package gets:
  - function num_zero_stream_random(NUM_SHARES), returning NUM_SHARES;
  - typedef of the share word, parametrised by BIT_WIDTH;
  - localparam encodings ZERO_MODE_INDEPENDENT = 0 and ZERO_MODE_RING = 1.
- Sub-module masked_zero_mix: purely combinational, one lane, NUM_SHARES words in, NUM_SHARES shares out, mode input. Instantiated NUM_LANES times.
- Buffer storage, pointers, occupancy and counter live in the top module and use the existing register module for state.

Test Plan:
All scenarios use NUM_SHARES=3, BIT_WIDTH=8, NUM_LANES=1, DEPTH=2 unless stated. Words are given as r0,r1,r2.

1. Reset: hold in_reset 2 cycles with in_valid=1 -> out_valid=0, out_random=0, out_count=0 throughout. in_ready=1 in the first cycle after release.
2. Independent mode: push r=0x11,0x22,0x33 with in_mode=0, out_ready=0 -> next cycle out_random shares = 0x11,0x22,0x33, out_valid=1.
3. Ring mode: push the same r with in_mode=1 -> shares = 0x33,0x11,0x22. Pop -> out_count=1 and out_random=0.
4. Back-pressure: out_ready=0, offer 3 beats -> first 2 accepted, then in_ready=0. Raise out_ready with in_valid=1 -> push and pop in the same cycle, occupancy stays 2, order preserved.
5. Flush: with 2 entries, assert in_flush together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, out_random=0, out_count unchanged, pushed beat dropped.
6. Random stress, NUM_SHARES=5, NUM_LANES=4, COUNT_WIDTH=4:
   - every popped lane XORs to 0;
   - every popped beat matches the reference model;
   - after 16 pops out_count=0.
